// File: rtl/bf_proc.sv
// Multi-cycle Brainfuck core: fetches opcodes from a synchronous ROM and works on a synchronous
// cell RAM. Define BF_CELL8_EN for 8-bit wrapping cells on '+'/'-' and 8-bit loop zero tests.
module bf_proc #(
  parameter int unsigned DATA_ADDR_WIDTH  = 16,
  parameter int unsigned DATA_VALUE_WIDTH = 32,
  parameter int unsigned PROG_ADDR_WIDTH  = 16,
  parameter int unsigned PROG_VALUE_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  output logic [PROG_ADDR_WIDTH-1:0]  prog_addr,
  output logic                        prog_ren,
  input  logic [PROG_VALUE_WIDTH-1:0] prog_rval,
  output logic [DATA_ADDR_WIDTH-1:0]  data_addr,
  output logic                        data_ren,
  input  logic [DATA_VALUE_WIDTH-1:0] data_rval,
  output logic                        data_wen,
  output logic [DATA_VALUE_WIDTH-1:0] data_wval,
  output logic [7:0]                  stdout,
  output logic                        stdout_en
);

  typedef enum logic [2:0] {
    StFetch, StExec, StScanF, StScanB, StChkF, StChkB, StHalt
  } state_e;

  localparam logic [2:0] OpEnd   = 3'd0;
  localparam logic [2:0] OpRight = 3'd1;
  localparam logic [2:0] OpLeft  = 3'd2;
  localparam logic [2:0] OpInc   = 3'd3;
  localparam logic [2:0] OpDec   = 3'd4;
  localparam logic [2:0] OpOut   = 3'd5;
  localparam logic [2:0] OpOpen  = 3'd6;
  localparam logic [2:0] OpClose = 3'd7;

  localparam logic [PROG_ADDR_WIDTH-1:0]  PcOne   = 1;
  localparam logic [DATA_ADDR_WIDTH-1:0]  DpOne   = 1;
  localparam logic [DATA_VALUE_WIDTH-1:0] CellOne = 1;

  state_e                      state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [DATA_ADDR_WIDTH-1:0]  dp_q, dp_d;
  logic [PROG_ADDR_WIDTH-1:0]  depth_q, depth_d;
  logic [7:0]                  stdout_q, stdout_d;
  logic                        stdout_en_q, stdout_en_d;

  logic [2:0]                  op;
  logic                        cell_zero;
  logic [DATA_VALUE_WIDTH-1:0] cell_inc, cell_dec;
  logic                        unused_prog_bits;

  assign op               = prog_rval[2:0];
  assign unused_prog_bits = ^prog_rval[PROG_VALUE_WIDTH-1:3];

`ifdef BF_CELL8_EN
  logic unused_cell_bits;
  assign unused_cell_bits = ^data_rval[DATA_VALUE_WIDTH-1:8];
  assign cell_zero = (data_rval[7:0] == 8'd0);
  assign cell_inc  = {{(DATA_VALUE_WIDTH-8){1'b0}}, data_rval[7:0] + 8'd1};
  assign cell_dec  = {{(DATA_VALUE_WIDTH-8){1'b0}}, data_rval[7:0] - 8'd1};
`else
  assign cell_zero = (data_rval == '0);
  assign cell_inc  = data_rval + CellOne;
  assign cell_dec  = data_rval - CellOne;
`endif

  // The output pulse register is not frozen by en, so it always drops after one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      dp_q        <= '0;
      depth_q     <= '0;
      stdout_q    <= '0;
      stdout_en_q <= 1'b0;
    end else begin
      stdout_en_q <= stdout_en_d;
      if (en) begin
        state_q  <= state_d;
        pc_q     <= pc_d;
        dp_q     <= dp_d;
        depth_q  <= depth_d;
        stdout_q <= stdout_d;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dp_d        = dp_q;
    depth_d     = depth_q;
    stdout_d    = stdout_q;
    stdout_en_d = 1'b0;
    unique case (state_q)
      StFetch: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_q + PcOne;
        case (op)
          OpEnd: begin
            state_d = StHalt;
            pc_d    = pc_q;
          end
          OpRight: dp_d = dp_q + DpOne;
          OpLeft:  dp_d = dp_q - DpOne;
          OpOut: begin
            stdout_d    = data_rval[7:0];
            stdout_en_d = en;
          end
          OpOpen: begin
            if (cell_zero) begin
              depth_d = PcOne;
              state_d = StScanF;
            end
          end
          OpClose: begin
            if (!cell_zero) begin
              depth_d = PcOne;
              pc_d    = pc_q - PcOne;
              state_d = StScanB;
            end
          end
          default: ;
        endcase
      end
      StScanF: state_d = StChkF;
      StScanB: state_d = StChkB;
      StChkF: begin
        pc_d    = pc_q + PcOne;
        state_d = StScanF;
        case (op)
          OpEnd: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          OpOpen: depth_d = depth_q + PcOne;
          OpClose: begin
            depth_d = depth_q - PcOne;
            if (depth_q == PcOne) state_d = StFetch;
          end
          default: ;
        endcase
      end
      StChkB: begin
        if (op == OpClose) depth_d = depth_q + PcOne;
        else if (op == OpOpen) depth_d = depth_q - PcOne;
        if (op == OpOpen && depth_q == PcOne) begin
          pc_d    = pc_q + PcOne;
          state_d = StFetch;
        end else if (pc_q == '0) begin
          state_d = StHalt;
        end else begin
          pc_d    = pc_q - PcOne;
          state_d = StScanB;
        end
      end
      StHalt: ;
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    prog_ren  = 1'b0;
    data_ren  = 1'b0;
    data_wen  = 1'b0;
    data_wval = (op == OpDec) ? cell_dec : cell_inc;
    unique case (state_q)
      StFetch: begin
        prog_ren = en;
        data_ren = en;
      end
      StExec:           data_wen = en && (op == OpInc || op == OpDec);
      StScanF, StScanB: prog_ren = en;
      default: ;
    endcase
  end

  assign prog_addr = pc_q;
  assign data_addr = dp_q;
  assign stdout    = stdout_q;
  assign stdout_en = stdout_en_q;

endmodule

// File: tb/tb_bf_proc.sv
// Scoreboarded bench for bf_proc: an interpreter model predicts output bytes and final memory,
// a negedge monitor checks each stdout_en pulse and that no strobes appear while en is low.
module tb_bf_proc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [15:0] prog_addr;
  logic        prog_ren;
  logic [9:0]  prog_rval = '0;
  logic [15:0] data_addr;
  logic        data_ren;
  logic [31:0] data_rval = '0;
  logic        data_wen;
  logic [31:0] data_wval;
  logic [7:0]  stdout;
  logic        stdout_en;

  always #5 clk = ~clk;

  bf_proc dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .prog_addr(prog_addr),
    .prog_ren (prog_ren),
    .prog_rval(prog_rval),
    .data_addr(data_addr),
    .data_ren (data_ren),
    .data_rval(data_rval),
    .data_wen (data_wen),
    .data_wval(data_wval),
    .stdout   (stdout),
    .stdout_en(stdout_en)
  );

  logic [9:0]  rom [256];
  logic [31:0] ram [65536];
  logic        ram_clear = 1'b0;

  always @(posedge clk) begin
    if (prog_ren) prog_rval <= rom[prog_addr[7:0]];
    if (ram_clear) begin
      for (int i = 0; i < 65536; i++) ram[i] <= '0;
    end else begin
      if (data_ren) data_rval <= ram[data_addr];
      if (data_wen) ram[data_addr] <= data_wval;
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_out[$];
  logic [31:0] mcell[int];
  logic [15:0] m_dp;
  int          prog_ops[256];
  logic        strobes;

  assign strobes = prog_ren | data_ren | data_wen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected byte per pulse; also no strobes while stalled.
  always @(negedge clk) begin
    if (!reset) begin
      if (stdout_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stdout_extra: got %0h, expected no output", stdout);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (stdout !== e) begin
            n_fail++;
            $display("FAIL stdout_byte: got %0h, expected %0h", stdout, e);
          end
        end
      end
      if (!en) begin
        n_cmp++;
        if (strobes !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_strobe: got %b, expected 0", strobes);
        end
      end
    end
  end

  function automatic logic [31:0] cell_of(input int a);
    return mcell.exists(a) ? mcell[a] : 32'd0;
  endfunction

  function automatic bit is_zero(input logic [31:0] c);
`ifdef BF_CELL8_EN
    return (c & 32'hFF) == 0;
`else
    return c == 0;
`endif
  endfunction

  // Plain interpreter with a precomputed bracket match table; unmatched jumps halt.
  task automatic run_model(output bit ok);
    int match[256];
    int stk[$];
    int pc;
    int steps;
    bit done;
    logic [15:0] dp;
    logic [31:0] c;
    mcell.delete();
    m_out.delete();
    for (int i = 0; i < 256; i++) match[i] = -1;
    for (int i = 0; i < 256; i++) begin
      if (prog_ops[i] == 6) stk.push_back(i);
      if (prog_ops[i] == 7 && stk.size() > 0) begin
        int j;
        j = stk.pop_back();
        match[i] = j;
        match[j] = i;
      end
    end
    pc = 0; dp = 0; steps = 0; done = 0;
    while (!done && steps < 400) begin
      steps++;
      c = cell_of(int'(dp));
      case (prog_ops[pc])
        0: done = 1;
        1: dp = dp + 16'd1;
        2: dp = dp - 16'd1;
`ifdef BF_CELL8_EN
        3: mcell[int'(dp)] = (c + 32'd1) & 32'hFF;
        4: mcell[int'(dp)] = (c - 32'd1) & 32'hFF;
`else
        3: mcell[int'(dp)] = c + 32'd1;
        4: mcell[int'(dp)] = c - 32'd1;
`endif
        5: m_out.push_back(c[7:0]);
        6: if (is_zero(c)) begin
             if (match[pc] < 0) done = 1;
             else pc = match[pc];
           end
        7: if (!is_zero(c)) begin
             if (match[pc] < 0) done = 1;
             else pc = match[pc];
           end
        default: ;
      endcase
      if (!done) pc++;
    end
    ok = done;
    m_dp = dp;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < 256; i++) prog_ops[i] = 0;
    for (int i = 0; i < s.len(); i++) begin
      byte ch;
      ch = s[i];
      case (ch)
        ">": prog_ops[i] = 1;
        "<": prog_ops[i] = 2;
        "+": prog_ops[i] = 3;
        "-": prog_ops[i] = 4;
        ".": prog_ops[i] = 5;
        "[": prog_ops[i] = 6;
        "]": prog_ops[i] = 7;
        default: prog_ops[i] = 0;
      endcase
    end
  endtask

  task automatic gen_random();
    int d;
    int n;
    int k;
    d = 0; k = 0;
    n = $urandom_range(6, 22);
    for (int i = 0; i < 256; i++) prog_ops[i] = 0;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 8: prog_ops[k++] = 3;
        2: prog_ops[k++] = 4;
        3, 9: prog_ops[k++] = 1;
        4: prog_ops[k++] = 2;
        5: prog_ops[k++] = 5;
        6: if (d < 2) begin
             prog_ops[k++] = 6;
             prog_ops[k++] = 4;
             d++;
           end else prog_ops[k++] = 3;
        default: if (d > 0) begin
                   prog_ops[k++] = 7;
                   d--;
                 end else prog_ops[k++] = 5;
      endcase
    end
    while (d > 0) begin
      prog_ops[k++] = 7;
      d--;
    end
  endtask

  task automatic load_rom_and_reset();
    for (int i = 0; i < 256; i++) rom[i] = {7'($urandom), 3'(prog_ops[i])};
    reset = 1'b1;
    en = 1'b1;
    ram_clear = 1'b1;
    @(posedge clk); #1;
    ram_clear = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // mode 0: en held high; 1: random stalls; 2: one 10-cycle stall starting at cycle 20.
  task automatic exec_test(input int mode);
    int cyc;
    int idle;
    int quiet;
    logic [7:0] last;
    exp_q = m_out;
    last = (m_out.size() > 0) ? m_out[m_out.size()-1] : 8'h00;
    load_rom_and_reset();
    cyc = 0; idle = 0;
    while (idle < 3 && cyc < 20000) begin
      case (mode)
        1: en = ($urandom_range(0, 3) != 0);
        2: en = !(cyc >= 20 && cyc < 30);
        default: en = 1'b1;
      endcase
      @(negedge clk);
      if (en) idle = strobes ? 0 : idle + 1;
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (idle < 3) begin
      n_fail++;
      $display("FAIL halt_timeout: got running after %0d cycles, expected halt", cyc);
    end
    en = 1'b1;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (strobes) quiet++;
    end
    @(posedge clk); #1;
    check("halt_quiet", quiet, 0);
    check("out_remaining", exp_q.size(), 0);
    for (int i = 0; i < 8; i++) check($sformatf("cell%0d", i), ram[i], cell_of(i));
    check("final_dp", {16'd0, data_addr}, {16'd0, m_dp});
    check("final_stdout", {24'd0, stdout}, {24'd0, last});
  endtask

  task automatic directed(input string s, input int mode);
    bit ok;
    load_str(s);
    run_model(ok);
    exec_test(mode);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", {16'd0, prog_addr}, 32'd0);
    check("rst_dp", {16'd0, data_addr}, 32'd0);
    check("rst_stdout", {24'd0, stdout}, 32'd0);
    check("rst_stdout_en", {31'd0, stdout_en}, 32'd0);
    check("rst_fetch_ren", {31'd0, prog_ren & data_ren}, 32'd1);

    directed("+++.", 0);
    check("d_plus3_cell", ram[0], 32'd3);
    check("d_plus3_out", {24'd0, stdout}, 32'h03);

    directed(">++<+", 0);
    check("d_move_c0", ram[0], 32'd1);
    check("d_move_c1", ram[1], 32'd2);
    check("d_move_dp", {16'd0, data_addr}, 32'd0);

    directed("-.", 0);
`ifdef BF_CELL8_EN
    check("d_dec_cell", ram[0], 32'h0000_00FF);
`else
    check("d_dec_cell", ram[0], 32'hFFFF_FFFF);
`endif
    check("d_dec_out", {24'd0, stdout}, 32'hFF);

    directed("[+].", 0);
    check("d_skip_cell", ram[0], 32'd0);
    check("d_skip_out", {24'd0, stdout}, 32'h00);

    directed("++[>++[>+<-]<-]>>.", 0);
    check("d_nest_c2", ram[2], 32'd4);
    check("d_nest_out", {24'd0, stdout}, 32'h04);
    directed("++[>++[>+<-]<-]>>.", 2);
    check("d_stall_c2", ram[2], 32'd4);
    check("d_stall_out", {24'd0, stdout}, 32'h04);

    directed("+].", 0);
    directed("[.", 0);
    directed("+>+[<.]", 0);

    for (int t = 0; t < 20; t++) begin
      int tries;
      tries = 0;
      do begin
        gen_random();
        run_model(ok);
        tries++;
      end while (!ok && tries < 50);
      if (ok) exec_test(t % 2);
    end

    // Reset in the middle of a long-running loop.
    load_str("+[+]");
    exp_q.delete();
    load_rom_and_reset();
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_pc", {16'd0, prog_addr}, 32'd0);
    check("midrst_dp", {16'd0, data_addr}, 32'd0);
    check("midrst_stdout_en", {31'd0, stdout_en}, 32'd0);
    check("midrst_stdout", {24'd0, stdout}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
